sd_data_serial_to_parallel: RTL and testbench
=============================================

# sd_data_serial_to_parallel

Receive-side serial-to-parallel converter for the SD host DATA path.
- Sits between the SD card DAT[3:0] pins and the DATA physical-layer controller.
- Once armed by the controller, it waits for a start bit and assembles 4-bit nibbles into 32-bit words, presenting each word on `data_read_SP_Phy`.
- At the end of a block it checks the end bit (and per-lane CRC16 when compiled in) and pulses `reception_complete_SP_Phy` back to the controller.

## Interface
Parameters:
- `BLOCK_WORDS`, default 128: 32-bit words per block (128 = 512 bytes); legal range 1..1024.

Ports:
- `SD_CLK`  in  1  SD clock. Single clock domain; all logic is rising-edge.
- `RESET`  in  1  Asynchronous, active-high reset.
- `enable_SP`  in  1  Arm and hold the receiver (from the physical layer). Low aborts reception.
- `DAT_DIN`  in  4  DAT[3:0] sampled from the card. DAT[3] is the nibble MSB.
- `timeout_Reg`  in  16  Start-bit wait limit, in SD_CLK cycles. 0 means wait forever.
- `data_read_SP_Phy`  out  32  Last assembled word.
- `word_valid_SP`  out  1  One-cycle pulse: `data_read_SP_Phy` has been updated.
- `reception_complete_SP_Phy`  out  1  One-cycle pulse: block finished.
- `rx_error_SP`  out  1  End-bit or CRC error for the finished block.
- `timeout_SP`  out  1  One-cycle pulse: no start bit arrived within `timeout_Reg`.

## Operation
- States: IDLE, WAIT_START, RECEIVE, CRC (only with the macro), END_BIT.
- IDLE:
  - When `enable_SP`=1, go to WAIT_START.
  - On that transition, load the timeout counter with `timeout_Reg` and clear `rx_error_SP`.
- WAIT_START:
  - `DAT_DIN`==4'h0 is the start bit: go to RECEIVE with nibble and word counters at 0.
  - Otherwise, if `timeout_Reg`!=0, decrement the counter.
  - Counter at 1 with no start bit: pulse `timeout_SP` and go to IDLE.
- RECEIVE:
  - Every edge, shift `DAT_DIN` into a 28-bit shift register. The first nibble lands in bits [31:28] (MSB first).
  - On the 8th nibble: `data_read_SP_Phy` <= {shift[27:0], DAT_DIN}, and `word_valid_SP` is set for one cycle.
  - After word `BLOCK_WORDS`-1 completes, go to CRC if enabled, else to END_BIT.
- CRC: 16 edges; on each, every lane receives one CRC bit, MSB first.
- END_BIT:
  - Sample `DAT_DIN`. Any value other than 4'hF sets `rx_error_SP`.
  - Pulse `reception_complete_SP_Phy` and go to IDLE.
- Multi-block: if `enable_SP` stays high, IDLE re-enters WAIT_START on the next edge.
- Abort: `enable_SP`=0 in any non-IDLE state sends the FSM to IDLE on the next edge.
  - No `word_valid_SP` or complete pulse for a partial word.
  - `data_read_SP_Phy` keeps its last value.
- `rx_error_SP` holds from the complete pulse until the next IDLE→WAIT_START transition.
- Simultaneous start bit and timeout expiry: the start bit wins.

## Timing
- Reset values:
  - FSM in IDLE.
  - `data_read_SP_Phy`=32'h0.
  - All pulse outputs and `rx_error_SP` at 0.
  - Counters at 0.
  - RESET asserted mid-block returns to IDLE immediately, with no pulses.
- Let edge 0 be the edge that samples the start bit:
  - Nibble k of word w is sampled at edge 1+8w+k.
  - `word_valid_SP` for word w is high during the cycle after edge 8+8w.
- End bit is sampled at edge 8·`BLOCK_WORDS`+1, or +17 with CRC.
  - `reception_complete_SP_Phy` and the final `rx_error_SP` are high during the following cycle.
- IDLE→WAIT_START costs one cycle, so back-to-back blocks are separated by at least 2 cycles.
- Timeout: `timeout_SP` is high in the cycle after the `timeout_Reg`-th consecutive non-start sample.

## Configuration
- Macro `SD_SP_CRC16_EN`.
- Defined:
  - Four independent CRC16 registers (x^16+x^12+x^5+1, init 0), one per lane, updated over every data bit of that lane.
  - CRC state adds 16 cycles.
  - A mismatch on any lane sets `rx_error_SP`.
- Undefined:
  - No CRC logic and no CRC state; RECEIVE goes directly to END_BIT.
  - `rx_error_SP` reflects the end bit only.

## Test plan
- Reset: assert RESET mid-RECEIVE → all outputs 0 within the same cycle; FSM in IDLE; no pulses after release until a new start bit.
- Basic block, `BLOCK_WORDS`=2, no CRC, words 32'hCAFECAFE then 32'h12345678, end 4'hF:
  - `word_valid_SP` after edges 8 and 16, with the matching data.
  - Complete pulse after edge 17.
  - `rx_error_SP`=0.
- Timeout: `timeout_Reg`=100, DAT held 4'hF → `timeout_SP` pulse after the 100th sample; FSM in IDLE; no other pulses.
- Bad end bit 4'h7 on the same block → complete pulse with `rx_error_SP`=1.
- CRC build, `BLOCK_WORDS`=2:
  - Correct per-lane CRC16 → `rx_error_SP`=0; complete pulse after edge 33.
  - Flip one CRC bit on lane 2 → `rx_error_SP`=1.
- Abort and restart:
  - `enable_SP` dropped after 3 nibbles → IDLE, no pulses.
  - Re-enable and send 32'hDEADBEEF → correct word and complete pulse.

Source files
------------

// File: rtl/sd_data_serial_to_parallel.sv
// sd_data_serial_to_parallel
//   Receive-side serial-to-parallel converter for the SD host DATA path.
//   Once armed, it waits for a start bit (DAT = 4'h0) and packs 4-bit
//   nibbles, MSB nibble first, into 32-bit words. After BLOCK_WORDS words
//   it checks the end bit and pulses reception_complete_SP_Phy.
//   Optional feature macro: SD_SP_CRC16_EN. When it is defined, one CRC16
//   (x^16+x^12+x^5+1, init 0) runs per DAT lane, and the received CRC is
//   checked before the end bit.
module sd_data_serial_to_parallel #(
  parameter int BLOCK_WORDS = 128
) (
  input  logic        SD_CLK,
  input  logic        RESET,
  input  logic        enable_SP,
  input  logic [3:0]  DAT_DIN,
  input  logic [15:0] timeout_Reg,
  output logic [31:0] data_read_SP_Phy,
  output logic        word_valid_SP,
  output logic        reception_complete_SP_Phy,
  output logic        rx_error_SP,
  output logic        timeout_SP
);

  localparam int WCW = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam logic [WCW-1:0] LAST_WORD = WCW'(BLOCK_WORDS - 1);

`ifdef SD_SP_CRC16_EN
  typedef enum logic [2:0] {IDLE, WAIT_START, RECEIVE, CRC, END_BIT} state_t;
`else
  typedef enum logic [2:0] {IDLE, WAIT_START, RECEIVE, END_BIT} state_t;
`endif

  state_t         state;
  state_t         state_nxt;
  logic [15:0]    tmo_cnt;
  logic [2:0]     nib_cnt;
  logic [WCW-1:0] word_cnt;
  logic [27:0]    shift;

  // Decoded per-cycle actions
  logic arm;
  logic start_hit;
  logic tmo_hit;
  logic tmo_dec;
  logic shift_en;
  logic word_done;
  logic last_word;
  logic end_hit;
  logic crc_err;

`ifdef SD_SP_CRC16_EN
  logic [3:0][15:0] crc;
  logic [3:0]       crc_cnt;
  logic             crc_bad;
  logic             crc_en;

  // Serial CRC16-CCITT step: one data bit in, MSB-first polynomial shift
  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction
`endif

  // State register
  always_ff @(posedge SD_CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; dropping enable_SP aborts from any active state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (arm) state_nxt = WAIT_START;
      WAIT_START: begin
        if (!enable_SP)     state_nxt = IDLE;
        else if (start_hit) state_nxt = RECEIVE;
        else if (tmo_hit)   state_nxt = IDLE;
      end
      RECEIVE: begin
        if (!enable_SP)     state_nxt = IDLE;
`ifdef SD_SP_CRC16_EN
        else if (last_word) state_nxt = CRC;
`else
        else if (last_word) state_nxt = END_BIT;
`endif
      end
`ifdef SD_SP_CRC16_EN
      CRC: begin
        if (!enable_SP)             state_nxt = IDLE;
        else if (crc_cnt == 4'd15)  state_nxt = END_BIT;
      end
`endif
      END_BIT:    state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Output/action decode; a start bit takes priority over timeout expiry
  always_comb begin
    arm       = 1'b0;
    start_hit = 1'b0;
    tmo_hit   = 1'b0;
    tmo_dec   = 1'b0;
    shift_en  = 1'b0;
    word_done = 1'b0;
    end_hit   = 1'b0;
`ifdef SD_SP_CRC16_EN
    crc_en    = 1'b0;
`endif
    case (state)
      IDLE:       arm = enable_SP;
      WAIT_START: begin
        if (enable_SP) begin
          if (DAT_DIN == 4'h0) begin
            start_hit = 1'b1;
          end else if (timeout_Reg != 16'd0) begin
            if (tmo_cnt == 16'd1) tmo_hit = 1'b1;
            else                  tmo_dec = 1'b1;
          end
        end
      end
      RECEIVE: begin
        if (enable_SP) begin
          shift_en  = 1'b1;
          word_done = (nib_cnt == 3'd7);
        end
      end
`ifdef SD_SP_CRC16_EN
      CRC:        crc_en  = enable_SP;
`endif
      END_BIT:    end_hit = enable_SP;
      default:    ;
    endcase
  end

  assign last_word = word_done && (word_cnt == LAST_WORD);

`ifdef SD_SP_CRC16_EN
  assign crc_err = crc_bad;
`else
  assign crc_err = 1'b0;
`endif

  // Start-bit timeout counter, loaded when the receiver is armed
  always_ff @(posedge SD_CLK or posedge RESET) begin
    if (RESET)        tmo_cnt <= 16'd0;
    else if (arm)     tmo_cnt <= timeout_Reg;
    else if (tmo_dec) tmo_cnt <= tmo_cnt - 16'd1;
  end

  // Nibble/word position inside the block, cleared on the start bit
  always_ff @(posedge SD_CLK or posedge RESET) begin
    if (RESET) begin
      nib_cnt  <= 3'd0;
      word_cnt <= '0;
    end else if (start_hit) begin
      nib_cnt  <= 3'd0;
      word_cnt <= '0;
    end else if (shift_en) begin
      nib_cnt <= nib_cnt + 3'd1;
      if (word_done) word_cnt <= word_cnt + WCW'(1);
    end
  end

  // Nibble shift register and word output; the 8th nibble completes a word
  always_ff @(posedge SD_CLK or posedge RESET) begin
    if (RESET) begin
      shift            <= 28'd0;
      data_read_SP_Phy <= 32'd0;
    end else if (shift_en) begin
      shift <= {shift[23:0], DAT_DIN};
      if (word_done) data_read_SP_Phy <= {shift, DAT_DIN};
    end
  end

  // One-cycle status pulses
  always_ff @(posedge SD_CLK or posedge RESET) begin
    if (RESET) begin
      word_valid_SP             <= 1'b0;
      reception_complete_SP_Phy <= 1'b0;
      timeout_SP                <= 1'b0;
    end else begin
      word_valid_SP             <= word_done;
      reception_complete_SP_Phy <= end_hit;
      timeout_SP                <= tmo_hit;
    end
  end

  // Block error flag: cleared on arm, set from end bit / CRC at block end
  always_ff @(posedge SD_CLK or posedge RESET) begin
    if (RESET)        rx_error_SP <= 1'b0;
    else if (arm)     rx_error_SP <= 1'b0;
    else if (end_hit) rx_error_SP <= (DAT_DIN != 4'hF) | crc_err;
  end

`ifdef SD_SP_CRC16_EN
  // Per-lane CRC: accumulate over data bits, then compare against the
  // received CRC bits MSB first while shifting the register out
  always_ff @(posedge SD_CLK or posedge RESET) begin
    if (RESET) begin
      crc     <= '0;
      crc_cnt <= 4'd0;
      crc_bad <= 1'b0;
    end else if (start_hit) begin
      crc     <= '0;
      crc_cnt <= 4'd0;
      crc_bad <= 1'b0;
    end else if (shift_en) begin
      for (int l = 0; l < 4; l++) crc[l] <= crc16_step(crc[l], DAT_DIN[l]);
    end else if (crc_en) begin
      for (int l = 0; l < 4; l++) crc[l] <= {crc[l][14:0], 1'b0};
      crc_cnt <= crc_cnt + 4'd1;
      crc_bad <= crc_bad | (DAT_DIN != {crc[3][15], crc[2][15], crc[1][15], crc[0][15]});
    end
  end
`endif

endmodule

// File: tb/tb_sd_data_serial_to_parallel.sv
// Testbench for sd_data_serial_to_parallel (BLOCK_WORDS = 2).
// Expected outputs are scheduled by absolute edge number from the block
// timing rules; a compare process checks every cycle against that schedule.
module tb_sd_data_serial_to_parallel;

  localparam int BW = 2;
`ifdef SD_SP_CRC16_EN
  localparam int CRC_CYC = 16;
`else
  localparam int CRC_CYC = 0;
`endif

  logic        clk = 1'b0;
  logic        RESET;
  logic        enable_SP;
  logic [3:0]  DAT_DIN;
  logic [15:0] timeout_Reg;
  logic [31:0] data_read_SP_Phy;
  logic        word_valid_SP;
  logic        reception_complete_SP_Phy;
  logic        rx_error_SP;
  logic        timeout_SP;

  sd_data_serial_to_parallel #(.BLOCK_WORDS(BW)) dut (
    .SD_CLK                    (clk),
    .RESET                     (RESET),
    .enable_SP                 (enable_SP),
    .DAT_DIN                   (DAT_DIN),
    .timeout_Reg               (timeout_Reg),
    .data_read_SP_Phy          (data_read_SP_Phy),
    .word_valid_SP             (word_valid_SP),
    .reception_complete_SP_Phy (reception_complete_SP_Phy),
    .rx_error_SP               (rx_error_SP),
    .timeout_SP                (timeout_SP)
  );

  initial forever #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int ecount = 0;
  bit run    = 1'b0;

  // Expected-event schedule, keyed by the edge after which the output shows
  bit          exp_wv [int];
  logic [31:0] exp_wd [int];
  bit          exp_cmp[int];
  bit          exp_to [int];
  bit          exp_err[int];

  logic [31:0] model_data = 32'h0;
  logic        model_err  = 1'b0;
  bit          ew, ec, et;
  int          n_wv, n_cmp, n_to;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %h expected %h", name, ecount, act, exp);
    end
  endtask

  // Edge counter: value N during the cycle following edge N
  initial forever begin
    @(posedge clk);
    ecount++;
  end

  // Per-cycle comparison against the scheduled model
  initial forever begin
    @(negedge clk);
    if (RESET) begin
      model_data = 32'h0;
      model_err  = 1'b0;
    end else if (run) begin
      ew = exp_wv.exists(ecount);
      ec = exp_cmp.exists(ecount);
      et = exp_to.exists(ecount);
      if (ew) model_data = exp_wd[ecount];
      if (exp_err.exists(ecount)) model_err = exp_err[ecount];
      chk("word_valid", 32'(word_valid_SP), 32'(ew));
      chk("data_read", data_read_SP_Phy, model_data);
      chk("complete", 32'(reception_complete_SP_Phy), 32'(ec));
      chk("rx_error", 32'(rx_error_SP), 32'(model_err));
      chk("timeout", 32'(timeout_SP), 32'(et));
      n_wv  += 32'(word_valid_SP);
      n_cmp += 32'(reception_complete_SP_Phy);
      n_to  += 32'(timeout_SP);
    end
  end

  // Drive one DAT value, let one edge sample it, return 1 time unit after
  task automatic tick(input logic [3:0] d);
    DAT_DIN = d;
    @(posedge clk);
    #1;
  endtask

  task automatic arm();
    enable_SP = 1'b1;
    DAT_DIN   = 4'hF;
    @(posedge clk);
    #1;
    exp_err[ecount] = 1'b0;
  endtask

  task automatic clear_counts();
    n_wv = 0; n_cmp = 0; n_to = 0;
  endtask

`ifdef SD_SP_CRC16_EN
  // CRC as the remainder of M(x)*x^16 divided by x^16+x^12+x^5+1
  function automatic logic [15:0] crc_div(input logic [15:0] m);
    logic [16:0] r;
    logic        b;
    r = 17'h0;
    for (int i = 0; i < 32; i++) begin
      b = (i < 16) ? m[15 - i] : 1'b0;
      r = {r[15:0], b};
      if (r[16]) r = r ^ 17'h11021;
    end
    return r[15:0];
  endfunction
`endif

  // Full block: idle samples, start bit, two words, [CRC], end nibble
  task automatic send_block(input logic [31:0] w0, input logic [31:0] w1,
                            input logic [3:0] endnib, input int idle_nibs,
                            input bit crc_flip);
    logic [31:0] w[2];
    logic [3:0]  nib;
    logic [15:0] lane[4];
    int          e;
    w[0] = w0; w[1] = w1;
    for (int i = 0; i < idle_nibs; i++) tick(4'hF);
    tick(4'h0);
    e = ecount;
    for (int wi = 0; wi < BW; wi++) begin
      exp_wv[e + 8 + 8*wi] = 1'b1;
      exp_wd[e + 8 + 8*wi] = w[wi];
      for (int k = 0; k < 8; k++) begin
        nib = w[wi][31 - 4*k -: 4];
        for (int l = 0; l < 4; l++) lane[l][15 - (8*wi + k)] = nib[l];
        tick(nib);
      end
    end
`ifdef SD_SP_CRC16_EN
    for (int l = 0; l < 4; l++) lane[l] = crc_div(lane[l]);
    for (int i = 0; i < 16; i++) begin
      for (int l = 0; l < 4; l++) nib[l] = lane[l][15 - i];
      if (crc_flip && i == 3) nib[2] = ~nib[2];
      tick(nib);
    end
    exp_err[e + 8*BW + 1 + CRC_CYC] = (endnib != 4'hF) | crc_flip;
`else
    exp_err[e + 8*BW + 1 + CRC_CYC] = (endnib != 4'hF);
`endif
    exp_cmp[e + 8*BW + 1 + CRC_CYC] = 1'b1;
    tick(endnib);
    enable_SP = 1'b0;
    repeat (3) tick(4'hF);
  endtask

  // Start a block and drop enable after n nibbles
  task automatic abort_after(input int n);
    arm();
    tick(4'h0);
    for (int i = 0; i < n; i++) tick(4'(i + 9));
    enable_SP = 1'b0;
    tick(4'h3);
    repeat (4) tick(4'hF);
  endtask

  initial begin
    RESET       = 1'b1;
    enable_SP   = 1'b0;
    DAT_DIN     = 4'hF;
    timeout_Reg = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_data", data_read_SP_Phy, 32'h0);
    chk("reset_wv", 32'(word_valid_SP), 32'h0);
    chk("reset_cmp", 32'(reception_complete_SP_Phy), 32'h0);
    chk("reset_err", 32'(rx_error_SP), 32'h0);
    chk("reset_to", 32'(timeout_SP), 32'h0);
    RESET = 1'b0;
    run   = 1'b1;
    repeat (2) tick(4'hF);

    // Basic block, good end bit
    clear_counts();
    arm();
    send_block(32'hCAFECAFE, 32'h12345678, 4'hF, 2, 1'b0);
    chk("basic_last_word", data_read_SP_Phy, 32'h12345678);
    chk("basic_wv_count", 32'(n_wv), 32'd2);
    chk("basic_cmp_count", 32'(n_cmp), 32'd1);
    chk("basic_err", 32'(rx_error_SP), 32'h0);

    // Bad end bit; error flag must hold while idle
    clear_counts();
    arm();
    send_block(32'hCAFECAFE, 32'h12345678, 4'h7, 1, 1'b0);
    repeat (5) tick(4'hF);
    chk("badend_err_hold", 32'(rx_error_SP), 32'h1);
    chk("badend_cmp_count", 32'(n_cmp), 32'd1);

    // Timeout after 100 non-start samples
    clear_counts();
    timeout_Reg = 16'd100;
    arm();
    exp_to[ecount + 100] = 1'b1;
    repeat (100) tick(4'hF);
    enable_SP = 1'b0;
    repeat (4) tick(4'hF);
    chk("timeout_count", 32'(n_to), 32'd1);
    chk("timeout_no_word", 32'(n_wv + n_cmp), 32'd0);
    chk("timeout_data_kept", data_read_SP_Phy, 32'h12345678);

    // Start bit arrives on the sample that would expire the timeout
    clear_counts();
    timeout_Reg = 16'd5;
    arm();
    send_block(32'h89ABCDEF, 32'h01234567, 4'hF, 4, 1'b0);
    chk("startwins_to", 32'(n_to), 32'd0);
    chk("startwins_cmp", 32'(n_cmp), 32'd1);
    timeout_Reg = 16'd0;

    // Aborts: after 3 nibbles and just before the 8th nibble
    clear_counts();
    abort_after(3);
    abort_after(7);
    chk("abort_pulses", 32'(n_wv + n_cmp + n_to), 32'd0);
    chk("abort_data_kept", data_read_SP_Phy, 32'h01234567);

    // Restart after abort
    clear_counts();
    arm();
    send_block(32'hDEADBEEF, 32'h0BADF00D, 4'hF, 0, 1'b0);
    chk("restart_wv_count", 32'(n_wv), 32'd2);
    chk("restart_cmp_count", 32'(n_cmp), 32'd1);

`ifdef SD_SP_CRC16_EN
    // One corrupted CRC bit on lane 2
    clear_counts();
    arm();
    send_block(32'hCAFECAFE, 32'h12345678, 4'hF, 1, 1'b1);
    chk("crcflip_err", 32'(rx_error_SP), 32'h1);
`endif

    // Reset while word_valid is high mid-block
    arm();
    tick(4'h0);
    exp_wv[ecount + 8] = 1'b1;
    exp_wd[ecount + 8] = 32'hA5A5A5A5;
    for (int k = 0; k < 8; k++) tick(k[0] ? 4'h5 : 4'hA);
    RESET     = 1'b1;
    enable_SP = 1'b0;
    #1;
    chk("midreset_data", data_read_SP_Phy, 32'h0);
    chk("midreset_wv", 32'(word_valid_SP), 32'h0);
    chk("midreset_cmp", 32'(reception_complete_SP_Phy), 32'h0);
    chk("midreset_err", 32'(rx_error_SP), 32'h0);
    chk("midreset_to", 32'(timeout_SP), 32'h0);
    @(posedge clk);
    #1;
    RESET = 1'b0;
    clear_counts();
    repeat (12) tick(4'h0);
    chk("postreset_pulses", 32'(n_wv + n_cmp + n_to), 32'd0);

    run = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
